// File: rtl/slice_collector_pkg.sv
// Shared constants, FSM state encoding and slice bit indexing for the
// slice collector and its neighbours in the column-parity datapath.
package slice_collector_pkg;

    localparam int SIZE    = 5;
    localparam int MEMSIZE = 25;
    localparam int DEPTH   = 64;
    localparam int LANES   = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } collectState_t;

    // Bit position of (column i, row j) inside a slice word.
    function automatic int sliceBit(input int i, input int j);
        return SIZE * j + i;
    endfunction

endpackage

// File: rtl/slice_collector_if.sv
// Slice input and lane output handshakes of the slice collector.
interface slice_collector_if
    import slice_collector_pkg::*;
#(
    parameter int memsize = MEMSIZE,
    parameter int depth   = DEPTH
);
    logic [memsize-1:0] slice_in;
    logic               slice_valid;
    logic               slice_ready;
    logic [depth-1:0]   lane_out;
    logic [4:0]         lane_idx;
    logic               lane_valid;
    logic               lane_ack;

    modport master (
        output slice_in, slice_valid, lane_ack,
        input  slice_ready, lane_out, lane_idx, lane_valid
    );

    modport slave (
        input  slice_in, slice_valid, lane_ack,
        output slice_ready, lane_out, lane_idx, lane_valid
    );
endinterface

// File: rtl/my_register.sv
// Generic load-enabled register with synchronous active-high clear.
module my_register #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    // Hold unless loaded; reset wins over load.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/slice_collector_lane_buffer.sv
// Transpose buffer: written one slice column at a time, read one lane row
// at a time.
module lane_buffer
    import slice_collector_pkg::*;
#(
    parameter int memsize = LANES,
    parameter int depth   = DEPTH,
    localparam int zw     = $clog2(depth)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [zw-1:0]      z,
    input  logic [memsize-1:0] wdata,
    input  logic [4:0]         ridx,
    output logic [depth-1:0]   rdata
);

    logic [depth-1:0] mem [memsize];

    // Scatter each slice bit into column z of its lane row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < memsize; k++)
                mem[k] <= '0;
        end else if (we) begin
            for (int j = 0; j < SIZE; j++)
                for (int i = 0; i < SIZE; i++)
                    mem[sliceBit(i, j)][z] <= wdata[sliceBit(i, j)];
        end
    end

    // Out-of-range lane indices read as zero rather than X.
    always_comb begin
        rdata = '0;
        if (int'(ridx) < memsize)
            rdata = mem[ridx];
    end

endmodule

// File: rtl/slice_collector.sv
// Collects 64 slices into the transpose buffer, then drains the 25 lanes
// to the state-memory writer.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for start, no handshakes active
//   COLLECT | accepting slices, z counter walks 0..63
//   DRAIN   | presenting lanes, lane counter walks 0..24
//   DONE    | one-cycle completion pulse, back to IDLE
module slice_collector
    import slice_collector_pkg::*;
#(
    parameter int size    = SIZE,
    parameter int memsize = MEMSIZE,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    slice_collector_if.slave   bus,
    output logic               busy,
    output logic               done
);

    localparam int zw       = $clog2(depth);
    localparam int lastLane = size * size - 1;

    collectState_t state, nextState;

    logic [zw-1:0] zCount, zNext;
    logic          zLd;
    logic [4:0]    laneCount, laneNext;
    logic          laneLd;
    logic          bufWe;

    my_register #(.width(zw)) zReg (
        .clk (clk),
        .rst (rst),
        .ld  (zLd),
        .d   (zNext),
        .q   (zCount)
    );

    my_register #(.width(5)) laneReg (
        .clk (clk),
        .rst (rst),
        .ld  (laneLd),
        .d   (laneNext),
        .q   (laneCount)
    );

    lane_buffer #(.memsize(memsize), .depth(depth)) buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (bufWe),
        .z     (zCount),
        .wdata (bus.slice_in),
        .ridx  (laneCount),
        .rdata (bus.lane_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state, counter loads and buffer write enable.
    always_comb begin
        nextState = state;
        zLd       = 1'b0;
        zNext     = zCount + zw'(1);
        laneLd    = 1'b0;
        laneNext  = laneCount + 5'd1;
        bufWe     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = COLLECT;
                    zLd       = 1'b1;
                    zNext     = '0;
                    laneLd    = 1'b1;
                    laneNext  = '0;
                end
            end
            COLLECT: begin
                if (bus.slice_valid) begin
                    bufWe = 1'b1;
                    zLd   = 1'b1;
                    if (zCount == zw'(depth - 1))
                        nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.lane_ack) begin
                    laneLd = 1'b1;
                    // Park the lane index at 0 so it never leaves the buffer range.
                    if (laneCount == 5'(lastLane)) begin
                        laneNext  = '0;
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Handshake outputs come from registered state only.
    assign bus.slice_ready = (state == COLLECT);
    assign bus.lane_valid  = (state == DRAIN);
    assign bus.lane_idx    = laneCount;
    assign busy            = (state == COLLECT) || (state == DRAIN);
    assign done            = (state == DONE);

endmodule

// File: tb/tb_slice_collector.sv
// Directed bench for the slice collector.
module tb_slice_collector;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    slice_collector_if sif ();

    slice_collector dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (sif),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int doneCnt = 0;

    logic [24:0] sl [64];
    logic [63:0] gotLane [25];
    logic [63:0] savedLane [25];
    int cyc, idxErr, stableErr, validErr, busyErr, doneAt;
    bit timedOut;

    always @(negedge clk) if (done) doneCnt++;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic buildSlices(input int pat, input bit inv);
        logic [24:0] s;
        for (int z = 0; z < 64; z++) begin
            case (pat)
                0:       s = {25{z[0]}};
                1:       s = 25'd1 << (z % 25);
                default: s = 25'(z * 32'h9E3779B1) ^ 25'(z << 13) ^ 25'h0A5A5A5;
            endcase
            sl[z] = inv ? ~s : s;
        end
    endtask

    function automatic logic [63:0] expLane(input int k);
        logic [63:0] e;
        for (int z = 0; z < 64; z++) e[z] = sl[z][k];
        return e;
    endfunction

    // Drives one pass from IDLE; records lanes and protocol anomalies.
    task automatic doPass(input int vPeriod, input int ackPeriod, input int stopLanes,
                          input bit noise, input bit b2b);
        int ph, budget, accepted, lanes;
        bit took, ack, first;
        idxErr = 0; stableErr = 0; validErr = 0; busyErr = 0; doneAt = -1; timedOut = 0;
        start = 1'b1;
        cyc = 1;
        tick();
        start = 1'b0;
        ph = 0; budget = 0; accepted = 0;
        while (accepted < 64 && budget < 400) begin
            sif.slice_valid = ((ph % vPeriod) == 0);
            sif.slice_in = sif.slice_valid ? sl[accepted] : ~sl[accepted];
            start = noise && (accepted == 10);
            if (!busy) busyErr++;
            took = sif.slice_valid && sif.slice_ready;
            tick();
            ph++; budget++;
            if (took) accepted++;
        end
        if (accepted < 64) timedOut = 1;
        sif.slice_valid = 1'b0;
        start = 1'b0;
        ph = 0; budget = 0; lanes = 0; first = 1;
        while (lanes < stopLanes && budget < 400) begin
            if (!sif.lane_valid || sif.slice_ready) validErr++;
            if (!busy) busyErr++;
            if (sif.lane_idx !== 5'(lanes)) idxErr++;
            if (first) gotLane[lanes] = sif.lane_out;
            else if (sif.lane_out !== gotLane[lanes]) stableErr++;
            ack = ((ph % ackPeriod) == (ackPeriod - 1));
            sif.lane_ack = ack;
            if (noise) begin
                start = 1'b1;
                sif.slice_valid = 1'b1;
                sif.slice_in = 25'h1FFFFFF;
            end
            tick();
            ph++; budget++;
            if (ack) begin lanes++; first = 1; end
            else first = 0;
        end
        if (lanes < stopLanes) timedOut = 1;
        sif.lane_ack = 1'b0;
        sif.slice_valid = 1'b0;
        start = 1'b0;
        if (stopLanes == 25) begin
            if (done) doneAt = cyc;
            if (b2b) start = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        sif.slice_valid = 1'b0; sif.slice_in = '0; sif.lane_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (sif.slice_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", sif.slice_ready); end
        checks++; if (sif.lane_valid !== 1'b0) begin errors++; $display("FAIL reset_lane_valid: got %b want 0", sif.lane_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sif.lane_idx !== 5'd0) begin errors++; $display("FAIL reset_lane_idx: got %0d want 0", sif.lane_idx); end
        checks++; if (sif.lane_out !== 64'd0) begin errors++; $display("FAIL reset_lane_out: got %h want 0", sif.lane_out); end
    endtask

    task automatic test_reset_mid_drain();
        int d0;
        buildSlices(0, 0);
        d0 = doneCnt;
        doPass(1, 1, 7, 0, 0);
        checks++; if (sif.lane_idx !== 5'd7) begin errors++; $display("FAIL rstdrain_pre_idx: got %0d want 7", sif.lane_idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (sif.lane_valid !== 1'b0) begin errors++; $display("FAIL rstdrain_lane_valid: got %b want 0", sif.lane_valid); end
        checks++; if (sif.lane_idx !== 5'd0) begin errors++; $display("FAIL rstdrain_lane_idx: got %0d want 0", sif.lane_idx); end
        checks++; if (sif.lane_out !== 64'd0) begin errors++; $display("FAIL rstdrain_lane_out: got %h want 0", sif.lane_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstdrain_busy: got %b want 0", busy); end
        checks++; if (sif.slice_ready !== 1'b0) begin errors++; $display("FAIL rstdrain_ready: got %b want 0", sif.slice_ready); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (doneCnt !== d0) begin errors++; $display("FAIL rstdrain_done: got %0d pulses want 0", doneCnt - d0); end
    endtask

    task automatic test_full_pass();
        int d0;
        buildSlices(0, 0);
        d0 = doneCnt;
        doPass(1, 1, 25, 0, 0);
        checks++; if (timedOut !== 1'b0) begin errors++; $display("FAIL full_timeout: got %b want 0", timedOut); end
        checks++; if (doneAt !== 91) begin errors++; $display("FAIL full_latency: got %0d want 91", doneAt); end
        checks++; if (idxErr !== 0) begin errors++; $display("FAIL full_lane_idx_seq: got %0d errs want 0", idxErr); end
        checks++; if (validErr !== 0) begin errors++; $display("FAIL full_handshake: got %0d errs want 0", validErr); end
        checks++; if (busyErr !== 0) begin errors++; $display("FAIL full_busy: got %0d errs want 0", busyErr); end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (gotLane[k] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
                errors++; $display("FAIL full_lane%0d: got %h want aaaaaaaaaaaaaaaa", k, gotLane[k]);
            end
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_width: got %b want 0", done); end
        checks++; if (doneCnt - d0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", doneCnt - d0); end
    endtask

    task automatic test_walk();
        buildSlices(1, 0);
        doPass(1, 1, 25, 0, 0);
        checks++; if (gotLane[0] !== 64'h0004_0000_0200_0001) begin errors++; $display("FAIL walk_lane0: got %h want 0004000002000001", gotLane[0]); end
        checks++; if (gotLane[13] !== 64'h8000_0040_0000_2000) begin errors++; $display("FAIL walk_lane13: got %h want 8000004000002000", gotLane[13]); end
        checks++; if (gotLane[24] !== 64'h0002_0000_0100_0000) begin errors++; $display("FAIL walk_lane24: got %h want 0002000001000000", gotLane[24]); end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (gotLane[k] !== expLane(k)) begin errors++; $display("FAIL walk_lane%0d: got %h want %h", k, gotLane[k], expLane(k)); end
        end
    endtask

    task automatic test_backpressure();
        buildSlices(0, 0);
        doPass(2, 3, 25, 0, 0);
        checks++; if (timedOut !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", timedOut); end
        checks++; if (stableErr !== 0) begin errors++; $display("FAIL bp_lane_stable: got %0d errs want 0", stableErr); end
        checks++; if (idxErr !== 0) begin errors++; $display("FAIL bp_lane_idx: got %0d errs want 0", idxErr); end
        checks++; if (doneAt < 0) begin errors++; $display("FAIL bp_done: got no pulse want pulse"); end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (gotLane[k] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
                errors++; $display("FAIL bp_lane%0d: got %h want aaaaaaaaaaaaaaaa", k, gotLane[k]);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        buildSlices(2, 0);
        doPass(1, 1, 25, 1, 0);
        checks++; if (doneAt !== 91) begin errors++; $display("FAIL ign_latency: got %0d want 91", doneAt); end
        checks++; if (idxErr !== 0) begin errors++; $display("FAIL ign_lane_idx: got %0d errs want 0", idxErr); end
        checks++; if (validErr !== 0) begin errors++; $display("FAIL ign_handshake: got %0d errs want 0", validErr); end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (gotLane[k] !== expLane(k)) begin errors++; $display("FAIL ign_lane%0d: got %h want %h", k, gotLane[k], expLane(k)); end
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = doneCnt;
        buildSlices(2, 0);
        doPass(1, 1, 25, 0, 1);
        for (int k = 0; k < 25; k++) savedLane[k] = gotLane[k];
        checks++; if (savedLane[5] !== expLane(5)) begin errors++; $display("FAIL b2b_first_lane5: got %h want %h", savedLane[5], expLane(5)); end
        buildSlices(2, 1);
        doPass(1, 1, 25, 0, 0);
        checks++; if (doneAt !== 91) begin errors++; $display("FAIL b2b_latency: got %0d want 91", doneAt); end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (gotLane[k] !== ~savedLane[k]) begin errors++; $display("FAIL b2b_lane%0d: got %h want %h", k, gotLane[k], ~savedLane[k]); end
        end
        checks++; if (doneCnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", doneCnt - d0); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_drain();
        test_full_pass();
        test_walk();
        test_backpressure();
        test_ignored_inputs();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slice_collector.md
# slice_collector

Reassembles the column-parity stage's per-slice output back into lane order. It accepts 25-bit slices (one per z index) over a valid/ready handshake and stores them in a 25×64 bit buffer. Once all slices have arrived, it drains the 25 reassembled 64-bit lanes one at a time to the state-memory writer. It sits downstream of the column-parity module and is the write-back counterpart of the lane-to-slice reader that feeds it.

## Interface
- `size`, default 5: row/column dimension of a slice.
- `memsize`, default 25: bits per slice, equal to `size*size`.
- `depth`, default 64: slices per state, equal to lane width.
- `clk` in, 1: sole clock; all state updates on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: begin a collection pass; sampled only in IDLE.
- `slice_in` in, `memsize`: slice data; bit k = 5*j + i (i = column, j = row).
- `slice_valid` in, 1: `slice_in` holds a valid slice.
- `slice_ready` out, 1: block accepts a slice this cycle.
- `lane_out` out, `depth`: reassembled lane; bit z comes from slice z.
- `lane_idx` out, 5: lane index 0..24 of `lane_out`.
- `lane_valid` out, 1: `lane_out`/`lane_idx` are valid.
- `lane_ack` in, 1: consumer takes the current lane.
- `busy` out, 1: high in COLLECT or DRAIN.
- `done` out, 1: one-cycle pulse after the last lane is acked.

## Operation
- The FSM has four states: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - All handshake outputs are low.
  - `start`=1 moves to COLLECT and clears the z counter and the lane counter.
- COLLECT:
  - `slice_ready`=1.
  - On `slice_valid`&`slice_ready`, for every k in 0..24: `buffer[k][z] <= slice_in[k]`, then z increments.
  - Acceptance at z = `depth`-1 moves to DRAIN.
  - The z counter is 6 bits. It never wraps inside a pass; it is cleared on entry to COLLECT.
- DRAIN:
  - `lane_valid`=1, `lane_out`=`buffer[lane_idx]`.
  - On `lane_ack`, `lane_idx` increments.
  - An ack at `lane_idx`=24 moves to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - Buffer contents are retained until overwritten by the next pass.
- `start` outside IDLE is ignored.
- `slice_valid` outside COLLECT is ignored; the buffer is not written.
- `lane_ack` outside DRAIN is ignored.
- Buffer cells are never read and written in the same state, so there is no read/write hazard.

## Timing
- Reset values:
  - state = IDLE.
  - `slice_ready`, `lane_valid`, `busy`, `done` = 0.
  - `lane_idx` = 0; `lane_out` = 0, because the buffer is cleared by `rst`.
  - Internal z counter = 0.
- `rst` asserted mid-pass: the next edge returns to IDLE with everything cleared. Partial slices are discarded and no `done` is produced.
- `slice_ready` and `lane_valid` are decoded directly from registered state. There is no combinational path from `slice_valid` or `lane_ack` to any output.
- Throughput in COLLECT: one slice per cycle with `slice_valid` held high. The 64 slices take 64 cycles.
- First `lane_valid` appears the cycle after the 64th slice is accepted.
- Throughput in DRAIN: with `lane_ack` held high, one lane per cycle (25 cycles). `done` rises the cycle after the 25th ack.
- Minimum pass latency, from the `start` edge to `done`: 1 + 64 + 25 + 1 = 91 cycles.
- Back-to-back passes: `start` may be asserted in the cycle `done` is high. It is sampled in IDLE on the following cycle.

## Structure
- Shared package/include holds:
  - Constants `SIZE`=5, `MEMSIZE`=25, `DEPTH`=64, `LANES`=25.
  - The 2-bit state encoding: IDLE=0, COLLECT=1, DRAIN=2, DONE=3.
  - The slice bit-index macro 5*j+i, shared with the column-parity module.
- One sub-module, `lane_buffer`:
  - 25×`depth` register array.
  - Slice-column write port (`we`, `z`, 25-bit data).
  - Lane-row read port (5-bit index, `depth`-bit data).
  - Synchronous clear on `rst`.
- Counters and the FSM live in `slice_collector`. The z counter and lane counter use the existing `my_register` with `ld` enables.

## Test plan
- Reset during DRAIN at `lane_idx`=7 -> next cycle state IDLE, `lane_valid`=0, `lane_idx`=0, `lane_out`=0, `busy`=0; `done` never pulses.
- Full pass, slice z = `{25{z[0]}}` with `slice_valid` held high, `lane_ack` held high -> every lane = 64'hAAAA_AAAA_AAAA_AAAA; `lane_idx` steps 0..24 on consecutive cycles; `done` high exactly 91 cycles after the `start` edge.
- Single-bit walk: slice z has only bit (z mod 25) set -> lane k has 1s only at z where z mod 25 = k (lane 0 = bits 0, 25, 50).
- Backpressure: `slice_valid` toggles 1,0,1,0 and `lane_ack` asserted every third cycle -> same lane data as the uninterrupted run; `lane_out` stable while unacked; no slice lost or duplicated.
- Ignored inputs: `start` pulsed during COLLECT and DRAIN, `slice_valid`=1 with data 25'h1FFFFFF during DRAIN -> no state change, lane contents unaffected.
- Back-to-back passes: `start` asserted in the cycle `done` is high, second pass with inverted data -> second pass lanes are the bitwise complement of the first pass; exactly one `done` per pass.
